// File: rtl/proc_pkg.sv
// Shared definitions for the processor register-read path.
//   DATA_W        : register / bus data width
//   NUM_REGS_DEF  : default number of readable registers
//   rd_state_e    : reader FSM state encoding
package proc_pkg;
  localparam int DATA_W       = 20;
  localparam int NUM_REGS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    STALL   = 2'd2,
    HOLD    = 2'd3
  } rd_state_e;
endpackage

// File: rtl/reg_sel_mux.sv
// Combinational NUM_REGS:1 selector over the flattened register file.
//   sel       : register index
//   reg_flat  : reg i at bits [i*DATA_W +: DATA_W]
//   wr_en_vec : per-register write enables
//   data      : selected register value (0 when sel is out of range)
//   pending   : write pending on the selected register (0 when out of range)
//   in_range  : sel < NUM_REGS
module reg_sel_mux #(
  parameter int DATA_W   = 20,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 4
) (
  input  logic [SEL_W-1:0]           sel,
  input  logic [NUM_REGS*DATA_W-1:0] reg_flat,
  input  logic [NUM_REGS-1:0]        wr_en_vec,
  output logic [DATA_W-1:0]          data,
  output logic                       pending,
  output logic                       in_range
);
  always_comb begin
    data     = '0;
    pending  = 1'b0;
    in_range = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel == SEL_W'(i)) begin
        data     = reg_flat[i*DATA_W +: DATA_W];
        pending  = wr_en_vec[i];
        in_range = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reg_bus_reader.sv
// Read-side companion to the negedge-written enable-write registers.
// Accepts a read request, waits out any write pending on the target
// register, captures its value and holds it on a valid/ready bus.
//   clk, rst_n  : posedge clock, synchronous active-low reset
//   rd_req/rd_sel/rd_ready : request handshake from the control unit
//   reg_flat, wr_en_vec    : register values and their write enables
//   bus_out/bus_valid/bus_ready : result handshake to the ALU/memory bus
//   rd_err   : sticky, an out-of-range index was accepted
//   rd_count : completed bus handshakes, wrapping
module reg_bus_reader #(
  parameter int DATA_W   = proc_pkg::DATA_W,
  parameter int NUM_REGS = proc_pkg::NUM_REGS_DEF,
  parameter int SEL_W    = 4,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rd_req,
  input  logic [SEL_W-1:0]           rd_sel,
  output logic                       rd_ready,
  input  logic [NUM_REGS*DATA_W-1:0] reg_flat,
  input  logic [NUM_REGS-1:0]        wr_en_vec,
  output logic [DATA_W-1:0]          bus_out,
  output logic                       bus_valid,
  input  logic                       bus_ready,
  output logic                       rd_err,
  output logic [CNT_W-1:0]           rd_count
);
  import proc_pkg::*;

  // One extra bit so NUM_REGS == 2**SEL_W is representable.
  localparam logic [SEL_W:0] NR = (SEL_W+1)'(NUM_REGS);

  rd_state_e          state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0]  bus_out_q, bus_out_d;
  logic               bus_valid_q, bus_valid_d;
  logic               rd_err_q, rd_err_d;
  logic [CNT_W-1:0]   rd_count_q, rd_count_d;

  logic [DATA_W-1:0]  mux_data;
  logic               mux_pending;
  logic               mux_in_range;

  reg_sel_mux #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .SEL_W   (SEL_W)
  ) u_mux (
    .sel      (sel_q),
    .reg_flat (reg_flat),
    .wr_en_vec(wr_en_vec),
    .data     (mux_data),
    .pending  (mux_pending),
    .in_range (mux_in_range)
  );

  // In HOLD the consumer's ready passes straight through so a new request
  // can be taken on the same edge the current result is accepted.
  assign rd_ready = (state_q == IDLE) || ((state_q == HOLD) && bus_ready);

  logic accept;
  assign accept = rd_req && rd_ready;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    bus_out_d   = bus_out_q;
    bus_valid_d = bus_valid_q;
    rd_err_d    = rd_err_q || (accept && ({1'b0, rd_sel} >= NR));
    rd_count_d  = rd_count_q;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          sel_d   = rd_sel;
          state_d = CAPTURE;
        end
      end
      CAPTURE, STALL: begin
        // Out-of-range never reports pending, so it captures 0 at once.
        if (mux_pending) begin
          state_d = STALL;
        end else begin
          bus_out_d   = mux_in_range ? mux_data : '0;
          bus_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (bus_ready) begin
          rd_count_d  = rd_count_q + CNT_W'(1);
          bus_valid_d = 1'b0;
          if (rd_req) begin
            sel_d   = rd_sel;
            state_d = CAPTURE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
      rd_err_q    <= 1'b0;
      rd_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      bus_out_q   <= bus_out_d;
      bus_valid_q <= bus_valid_d;
      rd_err_q    <= rd_err_d;
      rd_count_q  <= rd_count_d;
    end
  end

  assign bus_out   = bus_out_q;
  assign bus_valid = bus_valid_q;
  assign rd_err    = rd_err_q;
  assign rd_count  = rd_count_q;
endmodule

// File: tb/tb_reg_bus_reader.sv
module tb_reg_bus_reader;
  localparam int DW = 20;
  localparam int NR = 8;
  localparam int SW = 4;
  localparam int CW = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 rd_req;
  logic [SW-1:0]        rd_sel;
  logic                 rd_ready;
  logic [NR*DW-1:0]     reg_flat;
  logic [NR-1:0]        wr_en_vec;
  logic [DW-1:0]        bus_out;
  logic                 bus_valid;
  logic                 bus_ready;
  logic                 rd_err;
  logic [CW-1:0]        rd_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  reg_bus_reader #(.DATA_W(DW), .NUM_REGS(NR), .SEL_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_ready(rd_ready), .reg_flat(reg_flat), .wr_en_vec(wr_en_vec),
    .bus_out(bus_out), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .rd_err(rd_err), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: an outstanding request (waiting to be captured)
  // and a held result, plus the sticky error flag and the handshake count.
  bit          m_busy, m_hold, m_err;
  int          m_sel;
  logic [DW-1:0] m_out;
  int          m_count;

  function automatic logic [DW-1:0] reg_of(input int s);
    logic [NR*DW-1:0] f;
    f = reg_flat;
    return (s < NR) ? f[s*DW +: DW] : '0;
  endfunction

  function automatic bit m_ready();
    return (!m_busy && !m_hold) || (m_hold && bus_ready);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_hold = 0; m_err = 0; m_sel = 0; m_out = '0; m_count = 0;
    end else begin
      bit rdy;
      rdy = m_ready();
      if (m_hold && bus_ready) begin
        m_count = (m_count + 1) % (1 << CW);
        m_hold  = 0;
      end else if (m_busy) begin
        if (!(m_sel < NR && wr_en_vec[m_sel])) begin
          m_out  = reg_of(m_sel);
          m_hold = 1;
          m_busy = 0;
        end
      end
      if (rd_req && rdy) begin
        m_busy = 1;
        m_sel  = int'(rd_sel);
        if (int'(rd_sel) >= NR) m_err = 1;
      end
    end
  end

  // Compare process: inputs change just after posedge, so negedge is quiet.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("bus_valid", 32'(bus_valid), 32'(m_hold));
      chk("bus_out",   32'(bus_out),   32'(m_out));
      chk("rd_ready",  32'(rd_ready),  32'(m_ready()));
      chk("rd_err",    32'(rd_err),    32'(m_err));
      chk("rd_count",  32'(rd_count),  32'(m_count));
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_reg(input int i, input logic [DW-1:0] v);
    reg_flat[i*DW +: DW] = v;
  endtask

  task automatic do_reset();
    rst_n = 0; cyc(); rst_n = 1;
  endtask

  initial begin
    logic [DW-1:0] held;
    logic [CW-1:0] cnt0;
    rst_n = 0; rd_req = 0; rd_sel = '0; bus_ready = 0; wr_en_vec = '0;
    reg_flat = '0;
    for (int i = 0; i < NR; i++) set_reg(i, DW'(32'h1000 * (i + 1)));
    cyc(); rst_n = 1; chk_en = 1;
    chk("reset_valid", 32'(bus_valid), 32'd0);
    chk("reset_count", 32'(rd_count), 32'd0);
    chk("reset_ready", 32'(rd_ready), 32'd1);

    // Idle read of reg 3
    set_reg(3, 20'hABCDE); rd_req = 1; rd_sel = 4'd3; bus_ready = 1;
    cyc(); rd_req = 0;
    chk("idle_not_yet", 32'(bus_valid), 32'd0);
    cyc();
    chk("idle_valid", 32'(bus_valid), 32'd1);
    chk("idle_data", 32'(bus_out), 32'hABCDE);
    cyc();
    chk("idle_drop", 32'(bus_valid), 32'd0);
    chk("idle_count", 32'(rd_count), 32'd1);

    // Write hazard on reg 5, then backpressure
    set_reg(5, 20'h55555); wr_en_vec = 8'h20; bus_ready = 0;
    rd_req = 1; rd_sel = 4'd5;
    cyc(); rd_req = 0;                 // accepted
    cyc(); chk("stall1", 32'(bus_valid), 32'd0);
    chk("stall1_ready", 32'(rd_ready), 32'd0);
    cyc(); chk("stall2", 32'(bus_valid), 32'd0);
    wr_en_vec = '0; set_reg(5, 20'h12345);
    cyc();
    chk("hazard_valid", 32'(bus_valid), 32'd1);
    chk("hazard_data", 32'(bus_out), 32'h12345);
    held = bus_out; cnt0 = rd_count;
    for (int k = 0; k < 4; k++) begin
      set_reg(5, DW'($urandom));
      cyc();
      chk("bp_valid", 32'(bus_valid), 32'd1);
      chk("bp_data", 32'(bus_out), 32'(held));
      chk("bp_ready", 32'(rd_ready), 32'd0);
      chk("bp_count", 32'(rd_count), 32'(cnt0));
    end
    bus_ready = 1; cyc();
    chk("bp_accept_count", 32'(rd_count), 32'd2);

    // Back-to-back reads of 0,1,2
    set_reg(0, 20'h00A0A); set_reg(1, 20'h11B1B); set_reg(2, 20'h22C2C);
    rd_req = 1; rd_sel = 4'd0; bus_ready = 1;
    cyc();
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("b2b_valid", 32'(bus_valid), 32'd1);
      chk("b2b_data", 32'(bus_out), 32'(reg_of(k)));
      rd_sel = SW'(k + 1);
      if (k == 2) rd_req = 0;
      cyc();
    end
    chk("b2b_count", 32'(rd_count), 32'd5);

    // Out-of-range read, then reset while holding
    do_reset();
    rd_req = 1; rd_sel = 4'd9; bus_ready = 0; wr_en_vec = '1;
    cyc(); rd_req = 0;
    cyc();
    chk("oob_valid", 32'(bus_valid), 32'd1);
    chk("oob_data", 32'(bus_out), 32'd0);
    chk("oob_err", 32'(rd_err), 32'd1);
    wr_en_vec = '0; rst_n = 0; cyc(); rst_n = 1;
    chk("rst_valid", 32'(bus_valid), 32'd0);
    chk("rst_err", 32'(rd_err), 32'd0);
    chk("rst_count", 32'(rd_count), 32'd0);
    chk("rst_ready", 32'(rd_ready), 32'd1);

    // Counter wrap: 17 completed reads with CNT_W=4
    rd_req = 1; rd_sel = 4'd1; bus_ready = 1;
    for (int k = 0; k < 35; k++) cyc();
    rd_req = 0;
    chk("wrap_count", 32'(rd_count), 32'd1);
    cyc(); cyc(); cyc();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      rd_req    = ($urandom_range(0, 2) != 0);
      rd_sel    = SW'($urandom_range(0, 9));
      bus_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < NR; i++) wr_en_vec[i] = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < NR; i++) set_reg(i, DW'($urandom));
      cyc();
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
